// File: rtl/controle_calculadora.sv
// Sequencer for the 3-bit BCD calculator: collects A, operation and B, holds them for LAT_CALC cycles, then latches the result.
// Optional macro CONT_OPERACOES_EN adds a saturating capture counter on port num_ops.
module controle_calculadora #(
    parameter int LAT_CALC = 1,
    parameter int W_CONT   = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [2:0]  valor,
    input  logic [1:0]  operacao,
    input  logic        confirma,
    input  logic        limpa,
    output logic [2:0]  calc_a,
    output logic [2:0]  calc_b,
    output logic        calc_o1,
    output logic        calc_o0,
    input  logic [3:0]  calc_d,
    input  logic [3:0]  calc_u,
    input  logic        calc_sinal,
    output logic [3:0]  dezena,
    output logic [3:0]  unidade,
    output logic        sinal,
    output logic        pronto,
    output logic        ocupado,
    output logic [2:0]  estado
`ifdef CONT_OPERACOES_EN
    ,
    output logic [W_CONT-1:0] num_ops
`endif
);

    typedef enum logic [2:0] {
        ESPERA_A  = 3'd0,
        ESPERA_OP = 3'd1,
        ESPERA_B  = 3'd2,
        CALCULA   = 3'd3,
        MOSTRA    = 3'd4
    } estado_t;

    localparam logic [3:0] ESPERA_INI = 4'(LAT_CALC - 1);

    estado_t    st;
    logic [3:0] espera;
    logic       captura;

    // Capture edge: last cycle of the settling window, unless a clear wins.
    assign captura = (st == CALCULA) && (espera == 4'd0) && !limpa;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st      <= ESPERA_A;
            espera  <= 4'd0;
            calc_a  <= 3'd0;
            calc_b  <= 3'd0;
            calc_o1 <= 1'b0;
            calc_o0 <= 1'b0;
            dezena  <= 4'd0;
            unidade <= 4'd0;
            sinal   <= 1'b0;
        end else if (limpa) begin
            st      <= ESPERA_A;
            espera  <= 4'd0;
            calc_a  <= 3'd0;
            calc_b  <= 3'd0;
            calc_o1 <= 1'b0;
            calc_o0 <= 1'b0;
            dezena  <= 4'd0;
            unidade <= 4'd0;
            sinal   <= 1'b0;
        end else begin
            case (st)
                ESPERA_A: begin
                    if (confirma) begin
                        calc_a <= valor;
                        st     <= ESPERA_OP;
                    end
                end
                ESPERA_OP: begin
                    if (confirma) begin
                        {calc_o1, calc_o0} <= operacao;
                        st                 <= ESPERA_B;
                    end
                end
                ESPERA_B: begin
                    if (confirma) begin
                        calc_b <= valor;
                        espera <= ESPERA_INI;
                        st     <= CALCULA;
                    end
                end
                CALCULA: begin
                    // Operands stay frozen here; confirma is deliberately ignored.
                    if (espera != 4'd0) begin
                        espera <= espera - 4'd1;
                    end else begin
                        dezena  <= calc_d;
                        unidade <= calc_u;
                        sinal   <= calc_sinal;
                        st      <= MOSTRA;
                    end
                end
                MOSTRA: begin
                    if (confirma) begin
                        calc_a <= valor;
                        st     <= ESPERA_OP;
                    end
                end
                default: begin
                    st     <= ESPERA_A;
                    espera <= 4'd0;
                end
            endcase
        end
    end

    assign estado  = st;
    assign ocupado = (st == CALCULA);
    assign pronto  = (st == MOSTRA);

`ifdef CONT_OPERACOES_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            num_ops <= '0;
        end else if (captura && (num_ops != {W_CONT{1'b1}})) begin
            num_ops <= num_ops + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_controle_calculadora.sv
// Randomized self-checking bench for controle_calculadora with a settling datapath model.
module tb_controle_calculadora;
    localparam int LAT = 3;
    localparam int WC  = 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] valor;
    logic [1:0] operacao;
    logic       confirma, limpa;
    logic [2:0] calc_a, calc_b;
    logic       calc_o1, calc_o0;
    logic [3:0] calc_d, calc_u;
    logic       calc_sinal;
    logic [3:0] dezena, unidade;
    logic       sinal, pronto, ocupado;
    logic [2:0] estado;
`ifdef CONT_OPERACOES_EN
    logic [WC-1:0] num_ops;
`endif

    controle_calculadora #(.LAT_CALC(LAT), .W_CONT(WC)) dut (
        .clk(clk), .rst_n(rst_n), .valor(valor), .operacao(operacao),
        .confirma(confirma), .limpa(limpa), .calc_a(calc_a), .calc_b(calc_b),
        .calc_o1(calc_o1), .calc_o0(calc_o0), .calc_d(calc_d), .calc_u(calc_u),
        .calc_sinal(calc_sinal), .dezena(dezena), .unidade(unidade), .sinal(sinal),
        .pronto(pronto), .ocupado(ocupado), .estado(estado)
`ifdef CONT_OPERACOES_EN
        , .num_ops(num_ops)
`endif
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int exp_ops = 0;
    logic [8:0] last_res;

    logic [21:0] all_out;
    assign all_out = {calc_a, calc_b, calc_o1, calc_o0, dezena, unidade, sinal, pronto, ocupado, estado};

    // Datapath model: {sinal, tens, units} of the arithmetic result.
    function automatic logic [8:0] dp(input logic [2:0] a, input logic [2:0] b, input logic [1:0] o);
        int ia, ib, r, m;
        ia = int'(a);
        ib = int'(b);
        case (o)
            2'd0:    r = ia + ib;
            2'd1:    r = ia - ib;
            2'd2:    r = ia * ib;
            default: r = ib - ia;
        endcase
        m = (r < 0) ? -r : r;
        return {r < 0, 4'(m / 10), 4'(m % 10)};
    endfunction

    // Datapath outputs read 9/9 until LAT-1 cycles after its inputs last changed.
    logic [2:0] pa, pb;
    logic [1:0] po;
    int         settle, age;
    logic       changed;
    assign changed = (calc_a != pa) || (calc_b != pb) || ({calc_o1, calc_o0} != po);
    assign age     = changed ? 0 : settle;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pa <= 3'd0; pb <= 3'd0; po <= 2'd0; settle <= 100;
        end else begin
            pa <= calc_a; pb <= calc_b; po <= {calc_o1, calc_o0};
            if (changed) settle <= 1;
            else if (settle < 100) settle <= settle + 1;
        end
    end
    always_comb begin
        {calc_sinal, calc_d, calc_u} = {1'b0, 4'd9, 4'd9};
        if (age >= LAT - 1) {calc_sinal, calc_d, calc_u} = dp(calc_a, calc_b, {calc_o1, calc_o0});
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [2:0] v, input logic [1:0] o);
        valor = v; operacao = o; confirma = 1'b1;
        tick();
        confirma = 1'b0;
    endtask

    task automatic pulse_limpa;
        limpa = 1'b1;
        tick();
        limpa = 1'b0;
    endtask

    task automatic check_ops(input string nm);
`ifdef CONT_OPERACOES_EN
        n_tests++;
        if (num_ops !== WC'(exp_ops)) begin
            n_fail++;
            $display("FAIL %s num_ops got %0d want %0d", nm, num_ops, exp_ops);
        end
`endif
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        for (int i = 0; i < 5; i++) begin
            valor = 3'($urandom); operacao = 2'($urandom);
            confirma = 1'($urandom); limpa = 1'($urandom);
            #3;
            n_tests++;
            if (all_out !== 22'd0) begin
                n_fail++;
                $display("FAIL reset_hold outputs got %h want 0", all_out);
            end
        end
        confirma = 1'b0; limpa = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        pulse_limpa();
        n_tests++;
        if (all_out !== 22'd0) begin
            n_fail++;
            $display("FAIL reset_then_limpa outputs got %h want 0", all_out);
        end
        exp_ops = 0;
        check_ops("reset");
    endtask

    task automatic test_calc(input bit chained, input logic [2:0] a, input logic [1:0] op, input logic [2:0] b);
        logic [8:0] exp;
        exp = dp(a, b, op);
        if (!chained) pulse_limpa();
        press(a, 2'($urandom));
        n_tests++;
        if (estado !== 3'd1 || calc_a !== a || pronto !== 1'b0) begin
            n_fail++;
            $display("FAIL calc_a_entry estado/calc_a/pronto got %0d/%0d/%0d want 1/%0d/0", estado, calc_a, pronto, a);
        end
        if (chained) begin
            n_tests++;
            if ({sinal, dezena, unidade} !== last_res) begin
                n_fail++;
                $display("FAIL chain_retain display got %h want %h", {sinal, dezena, unidade}, last_res);
            end
        end
        press(3'($urandom), op);
        n_tests++;
        if (estado !== 3'd2 || {calc_o1, calc_o0} !== op) begin
            n_fail++;
            $display("FAIL calc_op estado/op got %0d/%0d want 2/%0d", estado, {calc_o1, calc_o0}, op);
        end
        press(b, 2'($urandom));
        for (int i = 0; i < LAT; i++) begin
            n_tests++;
            if (ocupado !== 1'b1 || pronto !== 1'b0 || calc_a !== a || calc_b !== b || {calc_o1, calc_o0} !== op) begin
                n_fail++;
                $display("FAIL calc_busy cycle %0d ocupado/pronto/a/b got %0d/%0d/%0d/%0d want 1/0/%0d/%0d", i, ocupado, pronto, calc_a, calc_b, a, b);
            end
            valor = 3'($urandom); confirma = 1'($urandom);
            tick();
        end
        confirma = 1'b0;
        if (exp_ops < (1 << WC) - 1) exp_ops++;
        n_tests++;
        if (estado !== 3'd4 || pronto !== 1'b1 || ocupado !== 1'b0 || {sinal, dezena, unidade} !== exp
            || calc_a !== a || calc_b !== b) begin
            n_fail++;
            $display("FAIL calc_result estado/pronto/ocupado/res got %0d/%0d/%0d/%h want 4/1/0/%h", estado, pronto, ocupado, {sinal, dezena, unidade}, exp);
        end
        check_ops("capture");
        tick();
        tick();
        n_tests++;
        if (estado !== 3'd4 || {sinal, dezena, unidade} !== exp) begin
            n_fail++;
            $display("FAIL calc_hold estado/res got %0d/%h want 4/%h", estado, {sinal, dezena, unidade}, exp);
        end
        last_res = exp;
    endtask

    task automatic test_abort;
        pulse_limpa();
        press(3'd6, 2'd0);
        press(3'd0, 2'd2);
        press(3'd5, 2'd0);
        tick();
        limpa = 1'b1;
        tick();
        limpa = 1'b0;
        n_tests++;
        if (all_out !== 22'd0) begin
            n_fail++;
            $display("FAIL abort outputs got %h want 0", all_out);
        end
        check_ops("abort");
        for (int i = 0; i < LAT + 1; i++) tick();
        n_tests++;
        if (estado !== 3'd0 || pronto !== 1'b0 || {sinal, dezena, unidade} !== 9'd0) begin
            n_fail++;
            $display("FAIL abort_late estado/pronto/res got %0d/%0d/%h want 0/0/0", estado, pronto, {sinal, dezena, unidade});
        end
    endtask

    task automatic test_same_cycle;
        pulse_limpa();
        press(3'd4, 2'd0);
        press(3'd0, 2'd1);
        valor = 3'd7; confirma = 1'b1; limpa = 1'b1;
        tick();
        confirma = 1'b0; limpa = 1'b0;
        n_tests++;
        if (estado !== 3'd0 || calc_a !== 3'd0 || calc_b !== 3'd0 || ocupado !== 1'b0) begin
            n_fail++;
            $display("FAIL same_cycle estado/a/b got %0d/%0d/%0d want 0/0/0", estado, calc_a, calc_b);
        end
    endtask

    task automatic test_async_reset;
        press(3'd3, 2'd0);
        press(3'd0, 2'd3);
        #2 rst_n = 1'b0;
        #1;
        n_tests++;
        if (all_out !== 22'd0) begin
            n_fail++;
            $display("FAIL async_reset outputs got %h want 0", all_out);
        end
        exp_ops = 0;
        check_ops("async_reset");
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        rst_n = 1'b0; valor = 3'd0; operacao = 2'd0; confirma = 1'b0; limpa = 1'b0;
        last_res = 9'd0;
        test_reset();
        test_calc(1'b0, 3'd5, 2'd0, 3'd3);
        test_calc(1'b1, 3'd7, 2'd0, 3'd1);
        test_calc(1'b0, 3'd2, 2'd1, 3'd6);
        for (int i = 0; i < 12; i++)
            test_calc(1'($urandom), 3'($urandom), 2'($urandom), 3'($urandom));
        test_abort();
        test_same_cycle();
        test_calc(1'b0, 3'd7, 2'd2, 3'd7);
        test_async_reset();
        test_calc(1'b0, 3'd1, 2'd1, 3'd1);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/controle_calculadora.md
Name: controle_calculadora

Overview:
- Sequencer for the 3-bit BCD calculator datapath (two 3-bit operands, 2-bit operation select, outputs BCD tens, BCD units and sign).
- Collects operand A, operation and operand B from shared switches, one press of a confirm pulse at a time.
- Holds the operands stable at the datapath for a fixed settling window, then captures the BCD result and sign into display registers.
- Sits between the front-panel inputs (switches and debounced buttons) and the datapath/7-segment display path.

Parameters:
- LAT_CALC, 1, cycles between the operand B confirm and result capture; legal range 1..15.
- W_CONT, 8, width of the operation counter (used only with the optional feature).

Ports:
- clk  in  1  single system clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- valor  in  3  operand switches.
- operacao  in  2  operation select {o1,o0}.
- confirma  in  1  one-cycle pulse, already debounced.
- limpa  in  1  one-cycle clear pulse.
- calc_a  out  3  registered operand A to the datapath.
- calc_b  out  3  registered operand B to the datapath.
- calc_o1  out  1  registered operation bit 1.
- calc_o0  out  1  registered operation bit 0.
- calc_d  in  4  datapath BCD tens.
- calc_u  in  4  datapath BCD units.
- calc_sinal  in  1  datapath sign.
- dezena  out  4  held BCD tens.
- unidade  out  4  held BCD units.
- sinal  out  1  held sign.
- pronto  out  1  result valid.
- ocupado  out  1  high while in CALCULA.
- estado  out  3  current state code.

Behaviour:
- Reset (rst_n=0, asynchronous): every output 0, estado=ESPERA_A, internal wait counter 0.
- State codes: ESPERA_A=0, ESPERA_OP=1, ESPERA_B=2, CALCULA=3, MOSTRA=4. Codes 5-7 are unreachable; if entered, go to ESPERA_A on the next edge.
- ESPERA_A: on confirma, calc_a<=valor, go to ESPERA_OP.
- ESPERA_OP: on confirma, {calc_o1,calc_o0}<=operacao, go to ESPERA_B.
- ESPERA_B: on confirma, calc_b<=valor, wait counter<=LAT_CALC-1, go to CALCULA.
- CALCULA:
  - ocupado=1; confirma is ignored.
  - If the counter is nonzero, decrement it.
  - When the counter is 0, on that edge capture dezena<=calc_d, unidade<=calc_u, sinal<=calc_sinal, set pronto<=1, go to MOSTRA.
- Latency: confirma sampled in ESPERA_B at edge k gives capture and pronto=1 after edge k+LAT_CALC.
- MOSTRA:
  - pronto=1; display registers hold their values.
  - On confirma: calc_a<=valor, pronto<=0, go to ESPERA_OP (chained entry).
  - dezena, unidade and sinal keep the old result until the next capture.
- Operand and operation registers change only on their own confirm, on limpa or on reset. They are stable throughout CALCULA.
- Display registers change only on capture, limpa or reset.
- limpa (sampled in any state): go to ESPERA_A; calc_a, calc_b, calc_o1, calc_o0, dezena, unidade, sinal and pronto cleared to 0. During CALCULA it aborts with no capture.
- limpa and confirma in the same cycle: limpa wins; confirma is discarded.
- ocupado and pronto are decoded from the state and are never high together.
- Asynchronous reset mid-operation: immediate return to the reset values, independent of clk.

Optional Feature:
- CONT_OPERACOES_EN defined:
  - Adds output port num_ops [W_CONT-1:0].
  - Increments by 1 on every result capture.
  - Saturates at all-ones.
  - Cleared only by rst_n, not by limpa.
- Not defined: port and counter absent; behaviour otherwise identical.

Test Plan:
- Reset with inputs toggling -> all outputs 0, estado=0. Releasing rst_n and then pulsing limpa leaves all outputs 0.
- LAT_CALC=1, sequence valor=5 confirma, operacao=00 confirma, valor=3 confirma; datapath model drives d=0, u=8, sinal=0 -> one edge later estado=4, pronto=1, dezena=0, unidade=8, calc_a=5, calc_b=3.
- LAT_CALC=3, operands 2 and 6 with op=01; model drives d=0, u=4, sinal=1; model holds d/u at 9/9 until two cycles after the confirm -> ocupado=1 for exactly 3 cycles, captured result is 0/4/1, pronto rises on the 3rd edge.
- LAT_CALC=4, limpa two cycles into CALCULA -> estado=0, pronto=0, dezena=unidade=0, sinal=0, no capture. With CONT_OPERACOES_EN, num_ops is unchanged.
- In ESPERA_B, confirma and limpa in the same cycle -> estado=0, calc_b=0, calc_a=0.
- In MOSTRA (result 0/8), valor=7 confirma -> estado=1, calc_a=7, pronto=0, dezena=0, unidade=8 retained. With CONT_OPERACOES_EN and W_CONT=2, four captures give num_ops=3 (saturated).
